// File: rtl/vga_pkg.sv
// Shared constants, raster flag bundle and width helper for the VGA timing generator.
package vga_pkg;

  // 640x480@60 reference timing (25.175 MHz pixel clock).
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;

  // Coordinate fields are carried at a fixed width so the struct can live here;
  // the top slices them down to the port width.
  localparam int unsigned CoordW = 12;

  // hsync/vsync are "inside the pulse" flags; polarity is applied at the output,
  // so an all-zero (reset) bundle is the idle raster state.
  typedef struct packed {
    logic              hsync;
    logic              vsync;
    logic              de;
    logic              line_start;
    logic              frame_start;
    logic              vblank_start;
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
  } raster_flags_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// En-qualified shift register of raster flags; Depth 0 is a pass-through.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  raster_flags_t d,
  output raster_flags_t q,
  // frame_start flag that the last stage will load on the next en edge
  output logic          tail_frame_start
);

  if (Depth == 0) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl       = ^{clk, reset, en};
    assign q                = d;
    assign tail_frame_start = d.frame_start;
  end else begin : g_pipe
    raster_flags_t stage_q [Depth];

    // Advance all stages together on pixel-enable cycles only.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
      end else if (en) begin
        stage_q[0] <= d;
        for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[Depth-1];

    if (Depth == 1) begin : g_tail_in
      assign tail_frame_start = d.frame_start;
    end else begin : g_tail_stage
      assign tail_frame_start = stage_q[Depth-2].frame_start;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, registered flags, alignment delay, strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC      = DefHSync,
  parameter int unsigned H_BP        = DefHBp,
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned H_FP        = DefHFp,
  parameter int unsigned V_SYNC      = DefVSync,
  parameter int unsigned V_BP        = DefVBp,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned V_FP        = DefVFp,
  parameter logic        H_POL       = 1'b0,
  parameter logic        V_POL       = 1'b0,
  parameter int unsigned PIPE_DELAY  = 1,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             de,
  output logic [width_of(H_ACTIVE)-1:0]    x,
  output logic [width_of(V_ACTIVE)-1:0]    y,
  output logic                             line_start,
  output logic                             frame_start,
  output logic                             vblank_start,
  output logic [FRAME_CNT_W-1:0]           frame_cnt
);

  localparam int unsigned HTotal     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned VTotal     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW         = width_of(HTotal);
  localparam int unsigned VW         = width_of(VTotal);
  localparam int unsigned XW         = width_of(H_ACTIVE);
  localparam int unsigned YW         = width_of(V_ACTIVE);
  localparam int unsigned HActBeg    = H_SYNC + H_BP;
  localparam int unsigned HActEnd    = HActBeg + H_ACTIVE;
  localparam int unsigned VActBeg    = V_SYNC + V_BP;
  localparam int unsigned VActEnd    = VActBeg + V_ACTIVE;

  if (PIPE_DELAY > 8 || H_SYNC == 0 || H_BP == 0 || H_ACTIVE == 0 || H_FP == 0 ||
      V_SYNC == 0 || V_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || FRAME_CNT_W == 0 ||
      XW > CoordW || YW > CoordW) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  raster_flags_t  flags_d, flags_q, flags_out;
  logic           h_act, v_act;
  logic           en_q;
  logic           tail_frame_start;
  logic           frame_evt;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  // Raster counters: h wraps every line, v steps on the last pixel of a line.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == HW'(HTotal - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(VTotal - 1)) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // Decode flags and coordinates for the current counter position.
  always_comb begin
    flags_d              = '0;
    h_act                = (h_q >= HW'(HActBeg)) && (h_q < HW'(HActEnd));
    v_act                = (v_q >= VW'(VActBeg)) && (v_q < VW'(VActEnd));
    flags_d.hsync        = h_q < HW'(H_SYNC);
    flags_d.vsync        = v_q < VW'(V_SYNC);
    flags_d.de           = h_act && v_act;
    flags_d.line_start   = h_q == '0;
    flags_d.frame_start  = (h_q == '0) && (v_q == '0);
    flags_d.vblank_start = (h_q == '0) && (v_q == VW'(VActEnd));
    if (h_act && v_act) begin
      flags_d.x = CoordW'(h_q - HW'(HActBeg));
      flags_d.y = CoordW'(v_q - VW'(VActBeg));
    end
  end

  // Counter and first flag stage; en_q marks cycles right after the pipeline advanced.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      flags_q <= '0;
      en_q    <= 1'b0;
    end else begin
      en_q <= en;
      if (en) begin
        h_q     <= h_d;
        v_q     <= v_d;
        flags_q <= flags_d;
      end
    end
  end

  vga_sync_delay #(
    .Depth (PIPE_DELAY)
  ) u_sync_delay (
    .clk              (clk),
    .reset            (reset),
    .en               (en),
    .d                (flags_q),
    .q                (flags_out),
    .tail_frame_start (tail_frame_start)
  );

  // The frame flag about to land in the last stage, so the count moves with the strobe.
  assign frame_evt = (PIPE_DELAY == 0) ? flags_d.frame_start : tail_frame_start;

  // Frame counter, bumped on the edge that presents a new frame_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else if (en && frame_evt) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  logic unused_coord;
  assign unused_coord = ^{flags_out.x, flags_out.y};

  // Output stage: apply sync polarity and gate strobes to one clk per event.
  always_comb begin
    hsync        = flags_out.hsync ? H_POL : ~H_POL;
    vsync        = flags_out.vsync ? V_POL : ~V_POL;
    de           = flags_out.de;
    x            = flags_out.x[XW-1:0];
    y            = flags_out.y[YW-1:0];
    line_start   = flags_out.line_start & en_q;
    frame_start  = flags_out.frame_start & en_q;
    vblank_start = flags_out.vblank_start & en_q;
    frame_cnt    = frame_cnt_q;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a tiny raster (10x7 totals), three configurations.
module tb_vga_timing_gen;

  localparam int HS = 2, HB = 3, HA = 4, HF = 1;
  localparam int VS = 1, VB = 2, VA = 3, VF = 1;
  localparam int HT = HS + HB + HA + HF;  // 10
  localparam int VT = VS + VB + VA + VF;  // 7
  localparam int FT = HT * VT;            // 70

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  logic       hs_a, vs_a, de_a, ls_a, fs_a, vb_a;
  logic [1:0] x_a, y_a;
  logic [2:0] fc_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b, vb_b;
  logic [1:0] x_b, y_b;
  logic [2:0] fc_b;
  logic       hs_c, vs_c, de_c, ls_c, fs_c, vb_c;
  logic [1:0] x_c, y_c;
  logic [2:0] fc_c;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(1), .FRAME_CNT_W(3)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a), .vblank_start(vb_a),
    .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(3), .FRAME_CNT_W(3)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b), .vblank_start(vb_b),
    .frame_cnt(fc_b)
  );

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(0), .FRAME_CNT_W(3)
  ) dut_c (
    .clk(clk), .reset(reset), .en(en), .hsync(hs_c), .vsync(vs_c), .de(de_c),
    .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c), .vblank_start(vb_c),
    .frame_cnt(fc_c)
  );

  int   checks = 0;
  int   failures = 0;
  int   k = 0;          // en edges since reset release
  logic en_last = 1'b0; // en at the most recent clk edge
  int   de_cnt, ls_cnt, fs_cnt, vb_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output at en-edge k shows raster position k-1-dly.
  task automatic check_inst(input string nm, input int dly, input logic pol,
                            input logic hs, input logic vs, input logic de_o,
                            input logic [1:0] xo, input logic [1:0] yo,
                            input logic ls, input logic fs, input logic vb,
                            input logic [2:0] fc);
    int p, h, v, ex, ey, efc;
    logic ehs, evs, ede, els, efs, evb;
    p = k - 1 - dly;
    if (p < 0) begin
      ehs = ~pol; evs = ~pol; ede = 1'b0; ex = 0; ey = 0;
      els = 1'b0; efs = 1'b0; evb = 1'b0; efc = 0;
    end else begin
      h   = p % HT;
      v   = (p / HT) % VT;
      ehs = (h < HS) ? pol : ~pol;
      evs = (v < VS) ? pol : ~pol;
      ede = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      ex  = ede ? h - (HS + HB) : 0;
      ey  = ede ? v - (VS + VB) : 0;
      els = (h == 0) && en_last;
      efs = (h == 0) && (v == 0) && en_last;
      evb = (h == 0) && (v == VS + VB + VA) && en_last;
      efc = (p / FT + 1) % 8;
    end
    check({nm, "_hsync"}, hs, ehs);
    check({nm, "_vsync"}, vs, evs);
    check({nm, "_de"}, de_o, ede);
    check({nm, "_x"}, xo, ex);
    check({nm, "_y"}, yo, ey);
    check({nm, "_line_start"}, ls, els);
    check({nm, "_frame_start"}, fs, efs);
    check({nm, "_vblank_start"}, vb, evb);
    check({nm, "_frame_cnt"}, fc, efc);
  endtask

  task automatic check_all();
    check_inst("a", 1, 1'b0, hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, vb_a, fc_a);
    check_inst("b", 3, 1'b0, hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b, vb_b, fc_b);
    check_inst("c", 0, 1'b1, hs_c, vs_c, de_c, x_c, y_c, ls_c, fs_c, vb_c, fc_c);
  endtask

  // Starts and ends at a negedge. mode 0: en=1, 1: toggle, 2: random.
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = ~en;
        default: en = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      if (!reset) begin
        k = 0;
        en_last = 1'b0;
      end else begin
        en_last = en;
        if (en) k++;
      end
      #1;
      check_all();
      if (de_a) de_cnt++;
      if (ls_a) ls_cnt++;
      if (fs_a) fs_cnt++;
      if (vb_a) vb_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic clear_counts();
    de_cnt = 0; ls_cnt = 0; fs_cnt = 0; vb_cnt = 0;
  endtask

  initial begin
    @(negedge clk);
    // Held in reset with en high: everything idle, sync at inactive level.
    run(3, 0);
    check("rst_c_hsync_low", hs_c, 1'b0);
    check("rst_a_hsync_high", hs_a, 1'b1);

    // Release: frame_start after 1+PIPE_DELAY clk.
    reset = 1'b1;
    run(1, 0);
    check("c_fs_clk1", fs_c, 1'b1);
    check("a_fs_clk1", fs_a, 1'b0);
    run(1, 0);
    check("a_fs_clk2", fs_a, 1'b1);
    check("a_fc_clk2", fc_a, 3'd1);
    run(2, 0);
    check("b_fs_clk4", fs_b, 1'b1);
    check("b_fc_clk4", fc_b, 3'd1);

    // One full frame with en=1.
    run(40, 0);
    clear_counts();
    run(FT, 0);
    check("frame_de_count", de_cnt, HA * VA);
    check("frame_line_count", ls_cnt, VT);
    check("frame_fs_count", fs_cnt, 1);
    check("frame_vb_count", vb_cnt, 1);

    // en toggling: strobes still one clk per event.
    en = 1'b1;
    clear_counts();
    run(2 * FT, 1);
    check("toggle_line_count", ls_cnt, VT);
    check("toggle_fs_count", fs_cnt, 1);
    check("toggle_de_clks", de_cnt, 2 * HA * VA);

    // Random en, then long en=1 run through a frame_cnt wrap.
    run(300, 2);
    run(400, 0);

    // Asynchronous reset mid-frame: outputs clear with no clk edge.
    #2 reset = 1'b0;
    #1;
    k = 0;
    en_last = 1'b0;
    check_all();
    check("async_rst_a_fc", fc_a, 3'd0);
    @(negedge clk);
    run(2, 0);
    reset = 1'b1;
    run(1, 0);
    check("rerel_a_fs_clk1", fs_a, 1'b0);
    run(1, 0);
    check("rerel_a_fs_clk2", fs_a, 1'b1);
    check("rerel_a_fc", fc_a, 3'd1);
    run(150, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the next generation of the sync front end of the game display path. Generates horizontal and vertical sync with configurable polarity, a data-enable flag, active-area pixel coordinates, and single-cycle line, frame and vertical-blank strobes for the renderer and game logic. A configurable delay pipeline keeps sync and enable aligned with a renderer of known latency. A pixel enable input allows the system clock to run faster than the pixel rate.

## Interface
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- H_POL, 0, hsync level during the sync pulse (0 = active-low).
- V_POL, 0, vsync level during the sync pulse.
- PIPE_DELAY, 1, extra output stages, legal range 0..8.
- FRAME_CNT_W, 16, width of the frame counter.
- clk  in  1  system clock, one clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  pixel enable; the raster advances only on cycles where en=1.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- de  out  1  high while the current output pixel is in the active area.
- x  out  clog2(H_ACTIVE)  active-area column; 0 when de=0.
- y  out  clog2(V_ACTIVE)  active-area row; 0 when de=0.
- line_start  out  1  one-clk strobe at h position 0.
- frame_start  out  1  one-clk strobe at h=0, v=0.
- vblank_start  out  1  one-clk strobe at h=0, v=V_SYNC+V_BP+V_ACTIVE; this is the game-state update tick.
- frame_cnt  out  FRAME_CNT_W  count of frames output.

## Operation
- Derived values: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP, which is 800 by default. V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP, which is 525 by default.
- Raster origin: h=0, v=0 is the first cycle of the sync pulse. Segment order is sync, back porch, active, front porch.
- h_ctr counts 0..H_TOTAL-1 on each en cycle, then wraps to 0.
- v_ctr increments on the en cycle where h_ctr = H_TOTAL-1. v_ctr wraps from V_TOTAL-1 to 0.
- Sync levels:
  - hsync = H_POL while h_ctr < H_SYNC; otherwise it is ~H_POL.
  - vsync uses the same rule on v_ctr with V_SYNC and V_POL.
- de = h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- x = h_ctr-(H_SYNC+H_BP) and y = v_ctr-(V_SYNC+V_BP) when de=1.
- All flags and coordinates are computed from the counters and then registered. They then pass through PIPE_DELAY en-qualified stages.
- Strobe outputs equal the final-stage flag ANDed with en registered by one cycle. Each strobe is therefore high for exactly one clk per event, whatever the en duty cycle.
- frame_cnt increments by 1, with wrap, in the same clk that frame_start is high.
- Reset asserted, including mid-frame:
  - counters and every pipeline stage clear immediately;
  - hsync = ~H_POL, vsync = ~V_POL;
  - de, x, y, all strobes and frame_cnt = 0.
- After release, the raster restarts at h=0, v=0.
- Elaboration error if PIPE_DELAY > 8 or if any timing parameter is 0.

## Timing
- Latency from counter state to outputs is 1+PIPE_DELAY en cycles.
- With en=1 continuously and default parameters:
  - first frame_start occurs 1+PIPE_DELAY clk after reset release;
  - first de=1 (x=0, y=0) occurs 144+35*800+1+PIPE_DELAY clk after release.
- en=0 freezes counters and pipeline contents. Strobes do not repeat while frozen.
- Simultaneous events: at h=0, v=0, line_start and frame_start are both high in the same clk. The same applies to line_start and vblank_start.

## Structure
- Package vga_pkg holds:
  - default 640x480@60 timing constants;
  - a packed struct of raster flags {hsync, vsync, de, line_start, frame_start, vblank_start, x, y};
  - a clog2-based width helper.
- Sub-module vga_sync_delay is a PIPE_DELAY-deep, en-qualified shift register of that struct. At depth 0 it is a pass-through.

## Test plan
- Defaults, en=1: hsync low for 96 clk every 800 clk; vsync low for 1600 clk every 420000 clk.
- One frame, en=1: exactly 307200 de cycles. The x,y sequence is raster order from (0,0) to (639,479).
- en toggling 1/0: every period doubles. line_start is high for exactly 1 clk per line, 525 per frame.
- PIPE_DELAY=0 vs 3, same stimulus: all outputs shifted by exactly 3 en cycles; frame_cnt=1 after the first frame_start.
- H_POL=1, V_POL=1: sync pulses high; after reset, hsync=0 and vsync=0.
- Reset asserted at v=200, h=400: outputs reach reset values without waiting for a clk edge. After release, frame_start recurs at 1+PIPE_DELAY and frame_cnt restarts at 0.
